// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: instruction-memory address/data plus IF/ID pipeline and hazard signals.
// The fetch stage connects through the master modport; the memory/pipeline environment uses slave.
interface instruction_fetch_stage_if;
    logic [63:0] programCounter;
    logic [31:0] CPU_Instruction;
    logic        branchTaken;
    logic [63:0] branchTarget;
    logic        stall;
    logic        flush;
    logic [31:0] ifIdInstruction;
    logic [63:0] ifIdPC;
    logic        ifIdValid;
    logic        fetchFault;

    modport master (
        output programCounter,
        input  CPU_Instruction,
        input  branchTaken,
        input  branchTarget,
        input  stall,
        input  flush,
        output ifIdInstruction,
        output ifIdPC,
        output ifIdValid,
        output fetchFault
    );

    modport slave (
        input  programCounter,
        output CPU_Instruction,
        output branchTaken,
        output branchTarget,
        output stall,
        output flush,
        input  ifIdInstruction,
        input  ifIdPC,
        input  ifIdValid,
        input  fetchFault
    );
endinterface

// File: rtl/instruction_fetch_stage.sv
// LEGv8 IF stage: PC register, IF/ID pipeline register, branch redirect, stall/flush, sticky fault.
// Optional FETCH_PERF_COUNTERS_EN adds saturating fetchCount/stallCount outputs.
module instruction_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 64,
    parameter int unsigned PC_STEP    = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
`ifdef FETCH_PERF_COUNTERS_EN
    output logic [31:0]                 fetchCount,
    output logic [31:0]                 stallCount,
`endif
    instruction_fetch_stage_if.master   fetchBus
);

    localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;

    typedef enum logic [1:0] {BOOT, RUN, FAULT} fetchState_t;

    fetchState_t state, stateNext;
    logic [63:0] pcReg, pcNext, seqPc, seqPcRaw;
    logic [31:0] instrReg, instrNext;
    logic [63:0] ifIdPcReg, ifIdPcNext;
    logic        validReg, validNext;
    logic        faultReg, faultNext;
    logic        targetIllegal;
    logic        fetchEvent, stallEvent;

    assign seqPcRaw      = pcReg + 64'(PC_STEP);
    assign seqPc         = (seqPcRaw > LAST_PC) ? 64'd0 : seqPcRaw;
    assign targetIllegal = (fetchBus.branchTarget[1:0] != 2'b00) || (fetchBus.branchTarget > LAST_PC);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BOOT;
            pcReg     <= RESET_PC;
            instrReg  <= '0;
            ifIdPcReg <= '0;
            validReg  <= 1'b0;
            faultReg  <= 1'b0;
        end else begin
            state     <= stateNext;
            pcReg     <= pcNext;
            instrReg  <= instrNext;
            ifIdPcReg <= ifIdPcNext;
            validReg  <= validNext;
            faultReg  <= faultNext;
        end
    end

    always_comb begin
        stateNext  = state;
        pcNext     = pcReg;
        instrNext  = instrReg;
        ifIdPcNext = ifIdPcReg;
        validNext  = validReg;
        faultNext  = faultReg;
        fetchEvent = 1'b0;
        stallEvent = 1'b0;
        case (state)
            BOOT: begin
                stateNext = RUN;
                validNext = 1'b0;
            end
            RUN: begin
                stallEvent = fetchBus.stall && !fetchBus.branchTaken;
                if (fetchBus.branchTaken && targetIllegal) begin
                    stateNext = FAULT;
                    faultNext = 1'b1;
                    validNext = 1'b0;
                end else if (fetchBus.branchTaken) begin
                    pcNext    = fetchBus.branchTarget;
                    validNext = 1'b0;
                end else if (fetchBus.flush) begin
                    // Squashed entry keeps its stale word/PC; only the valid bit matters.
                    validNext = 1'b0;
                    if (!fetchBus.stall) pcNext = seqPc;
                end else if (!fetchBus.stall) begin
                    instrNext  = fetchBus.CPU_Instruction;
                    ifIdPcNext = pcReg;
                    validNext  = 1'b1;
                    pcNext     = seqPc;
                    fetchEvent = 1'b1;
                end
            end
            FAULT: begin
                validNext = 1'b0;
                faultNext = 1'b1;
            end
            default: begin
                stateNext = FAULT;
                validNext = 1'b0;
                faultNext = 1'b1;
            end
        endcase
    end

`ifdef FETCH_PERF_COUNTERS_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            if (fetchEvent && (fetchCount != '1)) fetchCount <= fetchCount + 32'd1;
            if (stallEvent && (stallCount != '1)) stallCount <= stallCount + 32'd1;
        end
    end
`else
    logic unusedEvents;
    assign unusedEvents = fetchEvent ^ stallEvent;
`endif

    assign fetchBus.programCounter  = pcReg;
    assign fetchBus.ifIdInstruction = instrReg;
    assign fetchBus.ifIdPC          = ifIdPcReg;
    assign fetchBus.ifIdValid       = validReg;
    assign fetchBus.fetchFault      = faultReg;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage with a combinational 16-word instruction memory.
module tb_instruction_fetch_stage;

    logic clock = 1'b0;
    logic reset_n;
    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] mem [16];

    instruction_fetch_stage_if bus ();

`ifdef FETCH_PERF_COUNTERS_EN
    logic [31:0] fetchCount, stallCount;
`endif

    instruction_fetch_stage #(
        .RESET_PC   (64'h0),
        .IMEM_BYTES (64),
        .PC_STEP    (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
`ifdef FETCH_PERF_COUNTERS_EN
        .fetchCount (fetchCount),
        .stallCount (stallCount),
`endif
        .fetchBus   (bus.master)
    );

    always #5 clock = ~clock;

    assign bus.CPU_Instruction = mem[bus.programCounter[5:2]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic br, input logic [63:0] tgt, input logic st, input logic fl);
        bus.branchTaken  = br;
        bus.branchTarget = tgt;
        bus.stall        = st;
        bus.flush        = fl;
    endtask

    initial begin
        mem[0] = 32'hF842802A;
        mem[1] = 32'hCB03004B;
        for (int i = 2; i < 16; i++) mem[i] = 32'hA0000000 + 32'(i);
        reset_n = 1'b0;
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        #12;
        check("rst_pc", bus.programCounter, 64'h0);
        check("rst_valid", 64'(bus.ifIdValid), 64'd0);
        check("rst_fault", 64'(bus.fetchFault), 64'd0);
        check("rst_instr", 64'(bus.ifIdInstruction), 64'd0);
        check("rst_ifidpc", bus.ifIdPC, 64'h0);
        reset_n = 1'b1;

        step(); // BOOT edge
        check("boot_valid", 64'(bus.ifIdValid), 64'd0);
        check("boot_pc", bus.programCounter, 64'h0);
        step();
        check("f0_pc", bus.ifIdPC, 64'h0);
        check("f0_instr", 64'(bus.ifIdInstruction), 64'hF842802A);
        check("f0_valid", 64'(bus.ifIdValid), 64'd1);
        step();
        check("f1_pc", bus.ifIdPC, 64'h4);
        check("f1_instr", 64'(bus.ifIdInstruction), 64'hCB03004B);
        check("f1_next", bus.programCounter, 64'h8);

        drive(1'b0, 64'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", bus.programCounter, 64'h8);
            check("stall_ifidpc", bus.ifIdPC, 64'h4);
            check("stall_valid", 64'(bus.ifIdValid), 64'd1);
        end
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        step();
        check("unstall_ifidpc", bus.ifIdPC, 64'h8);
        check("unstall_instr", 64'(bus.ifIdInstruction), 64'hA0000002);
        check("unstall_pc", bus.programCounter, 64'hC);

        drive(1'b1, 64'h10, 1'b1, 1'b0);
        step();
        check("br_pc", bus.programCounter, 64'h10);
        check("br_valid", 64'(bus.ifIdValid), 64'd0);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        step();
        check("br_ifidpc", bus.ifIdPC, 64'h10);
        check("br_instr", 64'(bus.ifIdInstruction), 64'hA0000004);
        check("br_valid2", 64'(bus.ifIdValid), 64'd1);

        drive(1'b0, 64'h0, 1'b0, 1'b1);
        step();
        check("flush_valid", 64'(bus.ifIdValid), 64'd0);
        check("flush_pc", bus.programCounter, 64'h18);
        drive(1'b0, 64'h0, 1'b1, 1'b1);
        step();
        check("flushstall_valid", 64'(bus.ifIdValid), 64'd0);
        check("flushstall_pc", bus.programCounter, 64'h18);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        step();
        check("postflush_ifidpc", bus.ifIdPC, 64'h18);
        check("postflush_valid", 64'(bus.ifIdValid), 64'd1);

        drive(1'b1, 64'h38, 1'b0, 1'b0);
        step();
        check("wrapbr_pc", bus.programCounter, 64'h38);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        step();
        check("wrap_pc3c", bus.programCounter, 64'h3C);
        step();
        check("wrap_ifidpc", bus.ifIdPC, 64'h3C);
        check("wrap_instr", 64'(bus.ifIdInstruction), 64'hA000000F);
        check("wrap_pc0", bus.programCounter, 64'h0);
        step();
        check("wrap_fetch0", 64'(bus.ifIdInstruction), 64'hF842802A);
        check("wrap_pc4", bus.programCounter, 64'h4);

        drive(1'b1, 64'h12, 1'b0, 1'b0);
        step();
        check("mis_fault", 64'(bus.fetchFault), 64'd1);
        check("mis_valid", 64'(bus.ifIdValid), 64'd0);
        check("mis_pc", bus.programCounter, 64'h4);
        drive(1'b1, 64'h20, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("fault_pc", bus.programCounter, 64'h4);
            check("fault_flag", 64'(bus.fetchFault), 64'd1);
            check("fault_valid", 64'(bus.ifIdValid), 64'd0);
        end

        #3 reset_n = 1'b0;
        #1;
        check("arst_pc", bus.programCounter, 64'h0);
        check("arst_fault", 64'(bus.fetchFault), 64'd0);
        check("arst_ifidpc", bus.ifIdPC, 64'h0);
        #1 reset_n = 1'b1;
        drive(1'b1, 64'h12, 1'b0, 1'b0);
        step(); // BOOT edge ignores the illegal redirect
        check("bootbr_fault", 64'(bus.fetchFault), 64'd0);
        check("bootbr_pc", bus.programCounter, 64'h0);
        drive(1'b0, 64'h0, 1'b0, 1'b0);
        step();
        check("rerun_ifidpc", bus.ifIdPC, 64'h0);
        check("rerun_pc", bus.programCounter, 64'h4);
        drive(1'b1, 64'h40, 1'b0, 1'b0);
        step();
        check("oor_fault", 64'(bus.fetchFault), 64'd1);
        check("oor_pc", bus.programCounter, 64'h4);
        check("oor_valid", 64'(bus.ifIdValid), 64'd0);
        drive(1'b0, 64'h0, 1'b0, 1'b0);

`ifdef FETCH_PERF_COUNTERS_EN
        #3 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        check("perf_rst", 64'(fetchCount), 64'd0);
        step(); // BOOT
        drive(1'b0, 64'h0, 1'b0, 1'b0); step(); step();
        drive(1'b0, 64'h0, 1'b1, 1'b0); step(); step();
        drive(1'b0, 64'h0, 1'b0, 1'b0); step();
        drive(1'b0, 64'h0, 1'b0, 1'b1); step();
        drive(1'b0, 64'h0, 1'b0, 1'b0); step(); step(); step();
        check("perf_fetch", 64'(fetchCount), 64'd6);
        check("perf_stall", 64'(stallCount), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
IF stage of the LEGv8 pipeline. Owns the PC register and drives the instruction-memory address. Captures the returned 32-bit big-endian word into the IF/ID pipeline register with a valid bit. Accepts branch redirect, hazard stall and flush, and enters a sticky fault state on an illegal redirect target.

Parameters:
RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned and < IMEM_BYTES
IMEM_BYTES, 64, instruction-memory size in bytes; legal PC range 0..IMEM_BYTES-4
PC_STEP, 4, sequential PC increment in bytes

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
programCounter  out  64  byte address to instruction memory; equals the PC register
CPU_Instruction  in  32  instruction word from memory; combinational, valid in the same cycle as programCounter
branchTaken  in  1  redirect request from EX/MEM
branchTarget  in  64  redirect byte address; sampled only when branchTaken=1
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  squash IF/ID contents (insert bubble)
ifIdInstruction  out  32  latched instruction
ifIdPC  out  64  PC of the latched instruction
ifIdValid  out  1  IF/ID holds a real instruction
fetchFault  out  1  sticky fault flag

Behaviour:
- Reset (asynchronous, reset_n=0):
  - programCounter=RESET_PC; ifIdInstruction=0; ifIdPC=0; ifIdValid=0; fetchFault=0; state=BOOT.
  - Reset asserted mid-operation discards all in-flight state immediately.
- States: BOOT, RUN, FAULT.
  - BOOT: one cycle after reset release. PC holds, ifIdValid stays 0, then goes to RUN. This gives memory one settle cycle.
  - RUN: normal fetch.
  - FAULT: PC frozen, ifIdValid=0, fetchFault=1. Exit only by reset.
- RUN next-state priority at each rising edge, highest first:
  1. branchTaken=1 with an illegal target (branchTarget[1:0]!=0, or branchTarget > IMEM_BYTES-4):
     - state goes to FAULT; ifIdValid<=0; PC unchanged.
  2. branchTaken=1 with a legal target:
     - PC<=branchTarget; ifIdValid<=0 (the wrong-path word is discarded).
     - Overrides stall and flush.
  3. flush=1:
     - ifIdValid<=0; ifIdInstruction and ifIdPC don't-care.
     - PC advances unless stall=1, in which case PC holds.
  4. stall=1:
     - PC, ifIdInstruction, ifIdPC and ifIdValid all hold.
  5. Otherwise:
     - ifIdInstruction<=CPU_Instruction; ifIdPC<=programCounter; ifIdValid<=1.
     - PC<=next sequential PC.
- Sequential PC = PC+PC_STEP. If that result is > IMEM_BYTES-4, wrap to 0. All arithmetic is 64-bit unsigned.
- Latency: a word addressed in cycle N appears on the IF/ID outputs after edge N+1. Throughput is one instruction per cycle when unstalled.
- Inputs branchTaken, stall and flush are ignored in BOOT and FAULT.
- fetchFault is registered and asserts the cycle after the faulting edge.

Optional Feature:
FETCH_PERF_COUNTERS_EN
- Defined:
  - Adds outputs fetchCount[31:0] and stallCount[31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
  - fetchCount increments on every edge where rule 5 loads a valid instruction.
  - stallCount increments on every RUN-state edge with stall=1 and branchTaken=0.
- Undefined: the ports and counter logic are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset release, memory words 0xF842802A, 0xCB03004B at 0x0 and 0x4; no stall -> BOOT cycle ifIdValid=0. Then ifIdPC=0x0 / 0xF842802A, then 0x4 / 0xCB03004B on consecutive edges.
- stall=1 for 3 cycles while PC=0x8 -> programCounter stays 0x8 and IF/ID holds the PC=0x4 word with valid=1. After release, the next edge latches PC=0x8.
- branchTaken=1, branchTarget=0x10, with stall=1 the same cycle -> next edge: PC=0x10, ifIdValid=0. Following edge: ifIdPC=0x10, valid=1.
- Sequential run reaching PC=0x3C with IMEM_BYTES=64 -> next PC=0x0; ifIdPC=0x3C latched correctly.
- branchTarget=0x12 (misaligned), then separately 0x40 (out of range) -> fetchFault=1 and ifIdValid=0, with PC frozen across 5 cycles. Asserting reset_n=0 asynchronously clears the fault and restores PC=RESET_PC.
- With FETCH_PERF_COUNTERS_EN defined: 6 fetches, 2 stall cycles, 1 flush -> fetchCount=6, stallCount=2.
